// File: rtl/cernbe_vme_regbank_pkg.sv
// Shared types for the VME register bank: submap FSM states, timeout fill data, address decode.
// Combinational helpers only; no latency, no flow control.
// Backpressure: not applicable.
package cernbe_vme_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SM_RD = 2'd1,
        SM_WR = 2'd2
    } sm_state_t;

    localparam logic [15:0] C_TIMEOUT_DATA = 16'hDEAD;

    typedef struct packed {
        logic [15:0] reg_idx;
        logic [1:0]  word_idx;
    } addr_dec_t;

    // Word address -> (register, word); word 0 is the most significant word.
    function automatic addr_dec_t decode_addr(input logic [15:0] wa, input int reg_words);
        addr_dec_t d;
        d.reg_idx  = 16'(int'(wa) / reg_words);
        d.word_idx = 2'(int'(wa) % reg_words);
        return d;
    endfunction

endpackage

// File: rtl/cernbe_vme_atomic_reg.sv
// One multi-word register with write shadow (atomic commit) and coherent read latch.
// Write lands one cycle after wr_vld; rd_dat is combinational from the current word select.
// Backpressure: none, every request is taken the cycle it is presented.
module cernbe_vme_atomic_reg #(
    parameter int REG_WORDS = 2,
    parameter bit ATOMIC    = 1'b1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      wr_vld,
    input  logic [1:0]                wr_word,
    input  logic [15:0]               wr_dat,
    input  logic                      rd_vld,
    input  logic [1:0]                rd_word,
    output logic [15:0]               rd_dat,
    output logic [REG_WORDS*16-1:0]   value,
    output logic                      wr_pulse
);

    // Single-word registers have nothing to stage, so they always behave directly.
    localparam bit         STAGED = ATOMIC && (REG_WORDS > 1);
    localparam logic [1:0] LAST   = 2'(REG_WORDS - 1);

    logic [15:0] word_q   [REG_WORDS];
    logic [15:0] shadow_q [REG_WORDS];
    logic [15:0] latch_q  [REG_WORDS];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < REG_WORDS; i++) begin
                word_q[i]   <= '0;
                shadow_q[i] <= '0;
                latch_q[i]  <= '0;
            end
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= wr_vld && (!STAGED || wr_word == LAST);
            if (wr_vld) begin
                for (int i = 0; i < REG_WORDS; i++) begin
                    if (!STAGED) begin
                        if (wr_word == 2'(i)) word_q[i] <= wr_dat;
                    end else if (wr_word == LAST) begin
                        word_q[i] <= (i == REG_WORDS - 1) ? wr_dat : shadow_q[i];
                    end else if (wr_word == 2'(i)) begin
                        shadow_q[i] <= wr_dat;
                    end
                end
            end
            if (STAGED && rd_vld && rd_word == 2'd0) begin
                for (int i = 0; i < REG_WORDS; i++) latch_q[i] <= word_q[i];
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < REG_WORDS; i++) begin
            if (rd_word == 2'(i)) rd_dat = (STAGED && i != 0) ? latch_q[i] : word_q[i];
        end
    end

    always_comb begin
        value = '0;
        for (int i = 0; i < REG_WORDS; i++) value[(REG_WORDS-1-i)*16 +: 16] = word_q[i];
    end

endmodule

// File: rtl/cernbe_vme_regbank.sv
// VME slave: N_REGS multi-word registers plus one forwarded submap window with timeout.
// Register read acked 1 cycle after strobe, write 2 cycles; submap waits for its Done or TIMEOUT.
// Backpressure: strobes arriving while busy are dropped and never acknowledged.
module cernbe_vme_regbank
    import cernbe_vme_regbank_pkg::*;
#(
    parameter int AW        = 3,
    parameter int N_REGS    = 2,
    parameter int REG_WORDS = 2,
    parameter int ATOMIC    = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic [AW:1]                     VMEAddr,
    output logic [15:0]                     VMERdData,
    input  logic [15:0]                     VMEWrData,
    input  logic                            VMERdMem,
    input  logic                            VMEWrMem,
    output logic                            VMERdDone,
    output logic                            VMEWrDone,
    output logic [N_REGS*REG_WORDS*16-1:0]  regs_o,
    output logic [N_REGS-1:0]               regs_wr_o,
    output logic [AW-1:1]                   sm_VMEAddr_o,
    input  logic [15:0]                     sm_VMERdData_i,
    output logic [15:0]                     sm_VMEWrData_o,
    output logic                            sm_VMERdMem_o,
    output logic                            sm_VMEWrMem_o,
    input  logic                            sm_VMERdDone_i,
    input  logic                            sm_VMEWrDone_i,
    output logic                            sm_timeout_o,
    output logic [7:0]                      err_cnt_o
);

    sm_state_t   state, state_nxt;
    logic [15:0] tmo_cnt;
    logic        busy, acc_rd, acc_wr, sm_done, tmo_hit;
    logic [AW:1] d0_addr;
    logic [15:0] d0_wdata;
    logic        d0_wr;
    addr_dec_t   rd_dec, wr_dec;
    logic [15:0] reg_rd_dat [N_REGS];
    logic [15:0] reg_rd_sel;

    // A register write is still pending its ack while it sits in d0.
    assign busy   = (state != IDLE) || d0_wr;
    assign acc_wr = VMEWrMem && !busy;
    assign acc_rd = VMERdMem && !VMEWrMem && !busy;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            d0_addr  <= '0;
            d0_wdata <= '0;
            d0_wr    <= 1'b0;
        end else begin
            d0_wr <= acc_wr;
            if (acc_wr || acc_rd) begin
                d0_addr  <= VMEAddr;
                d0_wdata <= VMEWrData;
            end
        end
    end

    assign rd_dec = decode_addr(16'(VMEAddr[AW-1:1]), REG_WORDS);
    assign wr_dec = decode_addr(16'(d0_addr[AW-1:1]), REG_WORDS);

    for (genvar k = 0; k < N_REGS; k++) begin : g_reg
        cernbe_vme_atomic_reg #(
            .REG_WORDS (REG_WORDS),
            .ATOMIC    (ATOMIC != 0)
        ) u_reg (
            .Clk      (Clk),
            .Rst      (Rst),
            .wr_vld   (d0_wr && !d0_addr[AW] && wr_dec.reg_idx == 16'(k)),
            .wr_word  (wr_dec.word_idx),
            .wr_dat   (d0_wdata),
            .rd_vld   (acc_rd && !VMEAddr[AW] && rd_dec.reg_idx == 16'(k)),
            .rd_word  (rd_dec.word_idx),
            .rd_dat   (reg_rd_dat[k]),
            .value    (regs_o[k*REG_WORDS*16 +: REG_WORDS*16]),
            .wr_pulse (regs_wr_o[k])
        );
    end

    // Unmapped register addresses match no index and read as zero.
    always_comb begin
        reg_rd_sel = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (rd_dec.reg_idx == 16'(k)) reg_rd_sel = reg_rd_dat[k];
        end
    end

    assign sm_done = (state == SM_RD && sm_VMERdDone_i) || (state == SM_WR && sm_VMEWrDone_i);
    assign tmo_hit = (state != IDLE) && !sm_done && (tmo_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= (state == IDLE) ? 16'd0 : tmo_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc_wr && VMEAddr[AW])      state_nxt = SM_WR;
                else if (acc_rd && VMEAddr[AW]) state_nxt = SM_RD;
            end
            SM_RD, SM_WR: begin
                if (sm_done || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sm_VMERdMem_o  = (state == SM_RD) && (tmo_cnt == 16'd0);
        sm_VMEWrMem_o  = (state == SM_WR) && (tmo_cnt == 16'd0);
        sm_VMEAddr_o   = d0_addr[AW-1:1];
        sm_VMEWrData_o = d0_wdata;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            VMERdData    <= '0;
            VMERdDone    <= 1'b0;
            VMEWrDone    <= 1'b0;
            sm_timeout_o <= 1'b0;
            err_cnt_o    <= '0;
        end else begin
            VMERdDone    <= 1'b0;
            VMEWrDone    <= 1'b0;
            sm_timeout_o <= tmo_hit;
            if (acc_rd && !VMEAddr[AW]) begin
                VMERdDone <= 1'b1;
                VMERdData <= reg_rd_sel;
            end
            if (d0_wr && !d0_addr[AW]) VMEWrDone <= 1'b1;
            if (state == SM_RD && (sm_done || tmo_hit)) begin
                VMERdDone <= 1'b1;
                VMERdData <= sm_done ? sm_VMERdData_i : C_TIMEOUT_DATA;
            end
            if (state == SM_WR && (sm_done || tmo_hit)) VMEWrDone <= 1'b1;
            if (tmo_hit && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_cernbe_vme_regbank.sv
// Directed bench: an ATOMIC=1/TIMEOUT=8 bank and an ATOMIC=0 single-register bank.
module tb_cernbe_vme_regbank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:1]  addr;
    logic [15:0] wdata, rdata, sm_rdata, sm_wdata;
    logic        rd, wr, rdone, wdone;
    logic [63:0] regs;
    logic [1:0]  regs_wr;
    logic [2:1]  sm_addr;
    logic        sm_rd, sm_wr, sm_rdone, sm_wdone, sm_tmo;
    logic [7:0]  err_cnt;

    logic [3:1]  n_addr;
    logic [15:0] n_wdata, n_rdata, n_sm_rdata, n_sm_wdata;
    logic        n_rd, n_wr, n_rdone, n_wdone;
    logic [31:0] n_regs;
    logic [0:0]  n_regs_wr;
    logic [2:1]  n_sm_addr;
    logic        n_sm_rd, n_sm_wr, n_sm_rdone, n_sm_wdone, n_sm_tmo;
    logic [7:0]  n_err_cnt;

    cernbe_vme_regbank #(.AW(3), .N_REGS(2), .REG_WORDS(2), .ATOMIC(1), .TIMEOUT(8)) dut (
        .Clk(clk), .Rst(rst), .VMEAddr(addr), .VMERdData(rdata), .VMEWrData(wdata),
        .VMERdMem(rd), .VMEWrMem(wr), .VMERdDone(rdone), .VMEWrDone(wdone),
        .regs_o(regs), .regs_wr_o(regs_wr), .sm_VMEAddr_o(sm_addr),
        .sm_VMERdData_i(sm_rdata), .sm_VMEWrData_o(sm_wdata), .sm_VMERdMem_o(sm_rd),
        .sm_VMEWrMem_o(sm_wr), .sm_VMERdDone_i(sm_rdone), .sm_VMEWrDone_i(sm_wdone),
        .sm_timeout_o(sm_tmo), .err_cnt_o(err_cnt)
    );

    cernbe_vme_regbank #(.AW(3), .N_REGS(1), .REG_WORDS(2), .ATOMIC(0), .TIMEOUT(255)) dut_na (
        .Clk(clk), .Rst(rst), .VMEAddr(n_addr), .VMERdData(n_rdata), .VMEWrData(n_wdata),
        .VMERdMem(n_rd), .VMEWrMem(n_wr), .VMERdDone(n_rdone), .VMEWrDone(n_wdone),
        .regs_o(n_regs), .regs_wr_o(n_regs_wr), .sm_VMEAddr_o(n_sm_addr),
        .sm_VMERdData_i(n_sm_rdata), .sm_VMEWrData_o(n_sm_wdata), .sm_VMERdMem_o(n_sm_rd),
        .sm_VMEWrMem_o(n_sm_wr), .sm_VMERdDone_i(n_sm_rdone), .sm_VMEWrDone_i(n_sm_wdone),
        .sm_timeout_o(n_sm_tmo), .err_cnt_o(n_err_cnt)
    );

    typedef struct {
        bit          sel;
        bit          rd;
        bit          wr;
        logic [3:1]  addr;
        logic [15:0] dat;
        bit          exp_rdone;
        bit          exp_wdone;
        logic [15:0] exp_rdata;
        logic [63:0] exp_regs;
        logic [1:0]  exp_wrp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe in cycle n, sample cycles n+1 and n+2 at the falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        logic        r1, w1, r2, w2;
        logic [15:0] d1;
        logic [63:0] rg;
        logic [1:0]  wp;
        @(negedge clk);
        if (v.sel) begin n_rd = v.rd; n_wr = v.wr; n_addr = v.addr; n_wdata = v.dat; end
        else       begin rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.dat; end
        @(negedge clk);
        rd = 0; wr = 0; n_rd = 0; n_wr = 0;
        r1 = v.sel ? n_rdone : rdone;
        w1 = v.sel ? n_wdone : wdone;
        d1 = v.sel ? n_rdata : rdata;
        @(negedge clk);
        r2 = v.sel ? n_rdone : rdone;
        w2 = v.sel ? n_wdone : wdone;
        rg = v.sel ? {32'h0, n_regs} : regs;
        wp = v.sel ? {1'b0, n_regs_wr} : regs_wr;
        check($sformatf("v%0d rddone", idx), {r1, r2}, {v.exp_rdone, 1'b0});
        check($sformatf("v%0d wrdone", idx), {w1, w2}, {1'b0, v.exp_wdone});
        if (v.exp_rdone) check($sformatf("v%0d rddata", idx), d1, v.exp_rdata);
        check($sformatf("v%0d regs", idx), rg, v.exp_regs);
        check($sformatf("v%0d regs_wr", idx), wp, v.exp_wrp);
    endtask

    initial begin
        int cnt, late;
        bit seen;
        rst = 1; rd = 0; wr = 0; addr = 0; wdata = 0;
        sm_rdata = 0; sm_rdone = 0; sm_wdone = 0;
        n_rd = 0; n_wr = 0; n_addr = 0; n_wdata = 0;
        n_sm_rdata = 0; n_sm_rdone = 0; n_sm_wdone = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("reset regs", regs, 64'h0);
        check("reset outs", {rdone, wdone, rdata, sm_rd, sm_wr, sm_tmo, err_cnt}, 0);

        //                 sel rd wr addr  dat      rdn wdn rdata    regs                      wrp
        vecs.push_back(vec_t'{0, 0, 1, 3'd0, 16'h1234, 0, 1, 16'h0000, 64'h0000_0000_0000_0000, 2'b00});
        vecs.push_back(vec_t'{0, 0, 1, 3'd1, 16'h5678, 0, 1, 16'h0000, 64'h0000_0000_1234_5678, 2'b01});
        vecs.push_back(vec_t'{0, 1, 0, 3'd0, 16'h0000, 1, 0, 16'h1234, 64'h0000_0000_1234_5678, 2'b00});
        vecs.push_back(vec_t'{0, 0, 1, 3'd0, 16'hAAAA, 0, 1, 16'h0000, 64'h0000_0000_1234_5678, 2'b00});
        vecs.push_back(vec_t'{0, 0, 1, 3'd1, 16'h5555, 0, 1, 16'h0000, 64'h0000_0000_AAAA_5555, 2'b01});
        vecs.push_back(vec_t'{0, 1, 0, 3'd1, 16'h0000, 1, 0, 16'h5678, 64'h0000_0000_AAAA_5555, 2'b00});
        vecs.push_back(vec_t'{0, 1, 0, 3'd0, 16'h0000, 1, 0, 16'hAAAA, 64'h0000_0000_AAAA_5555, 2'b00});
        vecs.push_back(vec_t'{0, 1, 0, 3'd1, 16'h0000, 1, 0, 16'h5555, 64'h0000_0000_AAAA_5555, 2'b00});
        vecs.push_back(vec_t'{0, 0, 1, 3'd2, 16'hCAFE, 0, 1, 16'h0000, 64'h0000_0000_AAAA_5555, 2'b00});
        vecs.push_back(vec_t'{0, 0, 1, 3'd3, 16'hF00D, 0, 1, 16'h0000, 64'hCAFE_F00D_AAAA_5555, 2'b10});
        vecs.push_back(vec_t'{0, 1, 0, 3'd3, 16'h0000, 1, 0, 16'h0000, 64'hCAFE_F00D_AAAA_5555, 2'b00});
        vecs.push_back(vec_t'{0, 1, 0, 3'd2, 16'h0000, 1, 0, 16'hCAFE, 64'hCAFE_F00D_AAAA_5555, 2'b00});
        vecs.push_back(vec_t'{0, 1, 0, 3'd3, 16'h0000, 1, 0, 16'hF00D, 64'hCAFE_F00D_AAAA_5555, 2'b00});
        vecs.push_back(vec_t'{0, 0, 1, 3'd1, 16'hBBBB, 0, 1, 16'h0000, 64'hCAFE_F00D_AAAA_BBBB, 2'b01});
        vecs.push_back(vec_t'{1, 1, 1, 3'd1, 16'h00FF, 0, 1, 16'h0000, 64'h0000_0000_0000_00FF, 2'b01});
        vecs.push_back(vec_t'{1, 0, 1, 3'd0, 16'h1111, 0, 1, 16'h0000, 64'h0000_0000_1111_00FF, 2'b01});
        vecs.push_back(vec_t'{1, 1, 0, 3'd0, 16'h0000, 1, 0, 16'h1111, 64'h0000_0000_1111_00FF, 2'b00});
        vecs.push_back(vec_t'{1, 0, 1, 3'd2, 16'h2222, 0, 1, 16'h0000, 64'h0000_0000_1111_00FF, 2'b00});
        vecs.push_back(vec_t'{1, 1, 0, 3'd3, 16'h0000, 1, 0, 16'h0000, 64'h0000_0000_1111_00FF, 2'b00});
        vecs.push_back(vec_t'{1, 1, 0, 3'd1, 16'h0000, 1, 0, 16'h00FF, 64'h0000_0000_1111_00FF, 2'b00});
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Submap read answered 3 cycles after the strobe; a write strobe mid-access is dropped.
        seen = 0;
        @(negedge clk); rd = 1; addr = 3'd4;
        @(negedge clk); rd = 0;
        check("sm rd strobe", {sm_rd, sm_wr}, 2'b10);
        check("sm addr", sm_addr, 2'd0);
        @(negedge clk); wr = 1; addr = 3'd0; wdata = 16'h9999;
        check("sm rd pulse width", sm_rd, 1'b0);
        @(negedge clk); wr = 0;
        @(negedge clk); sm_rdone = 1; sm_rdata = 16'hBEEF;
        check("sm rd early done", rdone, 1'b0);
        @(negedge clk); sm_rdone = 0; sm_rdata = 16'h0;
        check("sm rd done", {rdone, rdata, sm_tmo}, {1'b1, 16'hBEEF, 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wdone || rdone) seen = 1;
        end
        check("busy strobe ignored", {seen, regs}, {1'b0, 64'hCAFE_F00D_AAAA_BBBB});
        check("no error on done", err_cnt, 8'd0);

        // Submap write left unanswered runs into the 8-cycle timeout.
        @(negedge clk); wr = 1; addr = 3'd5; wdata = 16'h7777;
        @(negedge clk); wr = 0;
        check("sm wr strobe", {sm_wr, sm_addr, sm_wdata}, {1'b1, 2'd1, 16'h7777});
        cnt = 1;
        while (!wdone && cnt < 20) begin @(negedge clk); cnt++; end
        check("tmo wr done", wdone, 1'b1);
        check("tmo latency", cnt, 9);
        check("tmo pulse", {sm_tmo, err_cnt, sm_wdata}, {1'b1, 8'd1, 16'h7777});
        @(negedge clk);
        check("tmo pulse width", {sm_tmo, wdone}, 2'b00);

        late = 0;
        for (int i = 0; i < 299; i++) begin
            @(negedge clk); rd = 1; addr = 3'd6;
            @(negedge clk); rd = 0;
            cnt = 1;
            while (!rdone && cnt < 20) begin @(negedge clk); cnt++; end
            if (!rdone) late++;
            if (i == 253) check("err_cnt 255th", err_cnt, 8'd255);
        end
        check("tmo rd completions", late, 0);
        check("tmo rd data", rdata, 16'hDEAD);
        check("err_cnt saturated", err_cnt, 8'd255);

        // Reset two cycles into a submap read aborts it silently.
        seen = 0;
        @(negedge clk); rd = 1; addr = 3'd4;
        @(negedge clk); rd = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rdone || sm_rd) seen = 1;
        end
        check("rst abort no done", seen, 1'b0);
        check("rst clears", {regs, err_cnt}, 72'h0);
        @(negedge clk); rd = 1; addr = 3'd1;
        @(negedge clk); rd = 0;
        check("read after rst", {rdone, rdata}, {1'b1, 16'h0000});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cernbe_vme_regbank.md
Name: cernbe_vme_regbank

Overview:
Parametrised CERN-BE VME slave. It implements N_REGS read/write registers of REG_WORDS×16 bits plus one forwarded submap window. Compared with the current single-register block it adds:
- atomic multi-word write commit and coherent multi-word read;
- a submap access state machine with timeout and an error counter.
It sits between the board VME decoder and the application logic or a downstream submap.

Parameters:
- AW, 3: VMEAddr word-address MSB. Bit AW=1 selects the submap; bit AW=0 selects the registers.
- N_REGS, 2: number of registers. Must satisfy N_REGS*REG_WORDS <= 2^(AW-1).
- REG_WORDS, 2: 16-bit words per register, 1..4.
- ATOMIC, 1: 1 = staged commit and coherent read; 0 = each word is written and read directly.
- TIMEOUT, 255: cycles an unanswered submap access waits before forced completion, 1..65535.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset
- VMEAddr  in  AW  word address [AW:1]
- VMERdData  out  16  read data, registered
- VMEWrData  in  16  write data
- VMERdMem  in  1  read strobe, one-cycle pulse
- VMEWrMem  in  1  write strobe, one-cycle pulse
- VMERdDone  out  1  read acknowledge pulse
- VMEWrDone  out  1  write acknowledge pulse
- regs_o  out  N_REGS*REG_WORDS*16  register values; register k occupies slice k
- regs_wr_o  out  N_REGS  one-cycle commit pulse per register
- sm_VMEAddr_o  out  AW-1  submap word address [AW-1:1]
- sm_VMERdData_i  in  16  submap read data
- sm_VMEWrData_o  out  16  submap write data
- sm_VMERdMem_o  out  1  submap read strobe
- sm_VMEWrMem_o  out  1  submap write strobe
- sm_VMERdDone_i  in  1  submap read acknowledge
- sm_VMEWrDone_i  in  1  submap write acknowledge
- sm_timeout_o  out  1  one-cycle pulse on timeout
- err_cnt_o  out  8  saturating timeout count

Behaviour:
- Reset: one clock; synchronous, active-high reset Rst.
  - All outputs and registers reset to 0; FSM goes to IDLE.
  - Rst mid-access aborts it: strobes drop and no Done is issued for the aborted access.
- Word order within a register is big-endian: lowest word address = most significant word. Register k, word w sits at word address k*REG_WORDS+w.
- Input pipeline: VMEAddr, VMEWrData and the strobes are registered once (the d0 stage).
- Register read, strobe in cycle n:
  - VMERdData is valid and VMERdDone=1 in cycle n+1.
  - Unmapped address: data 0x0000, still acked in n+1.
- Register write, strobe in cycle n:
  - The write request is evaluated in n+1 and the target is updated at the n+1 edge.
  - VMEWrDone=1 in cycle n+2.
  - Unmapped write: acked in n+2 and discarded.
- ATOMIC=1 write: writes to words 0..REG_WORDS-2 go to a per-register shadow. The write to the last (least significant) word commits shadow+data to regs_o in a single cycle and pulses regs_wr_o[k]. Shadow contents persist until overwritten.
- ATOMIC=1 read: reading word 0 snapshots the remaining words into a per-register read latch. Reads of words 1..REG_WORDS-1 return latch contents.
- ATOMIC=0: each word updates regs_o immediately; regs_wr_o pulses on every word write.
- REG_WORDS=1: the register is always written and read directly, regardless of ATOMIC.
- Submap FSM states: IDLE, SM_RD, SM_WR.
  - IDLE→SM_RD or SM_WR on a strobe with VMEAddr[AW]=1. sm_VMERd/WrMem_o pulses for one cycle on entry.
  - sm_VMEAddr_o and sm_VMEWrData_o are held for the whole access.
  - On sm_*Done_i: forward Done. For reads, latch sm_VMERdData_i into VMERdData in the same registered cycle. Return to IDLE.
  - Timeout counter starts at 0 on entry and increments every cycle in SM_RD/SM_WR. At TIMEOUT with no Done:
    - force Done;
    - read data = 0xDEAD;
    - pulse sm_timeout_o;
    - increment err_cnt_o, saturating at 255.
  - Done and timeout in the same cycle: treated as a normal completion with no error.
- Busy rule: strobes arriving while not IDLE, or during a pending register ack, are ignored and produce no Done.
- Simultaneous VMERdMem and VMEWrMem: the write is serviced; the read is dropped.

Decomposition:
- Package cernbe_vme_regbank_pkg holds:
  - the FSM state enum;
  - constant C_TIMEOUT_DATA = 16'hDEAD;
  - a function returning the register index and word index from an address.
- Sub-module cernbe_vme_atomic_reg (one register: storage, shadow, read latch, commit pulse), generated N_REGS times.

Test Plan:
- Default parameters, ATOMIC=1: write 0x1234 to addr 0, then 0x5678 to addr 1.
  → regs_o[31:0] stays 0 after the first write, becomes 0x12345678 after the second; regs_wr_o[0] pulses once; VMEWrDone 2 cycles after each strobe.
- regs_o[31:0]=0x12345678: read addr 0, then change the register to 0xAAAA5555 via writes, then read addr 1.
  → returns 0x1234, then the latched 0x5678.
- Submap read at addr 4 with sm_VMERdDone_i asserted 3 cycles after sm_VMERdMem_o, sm_VMERdData_i=0xBEEF.
  → sm_VMEAddr_o=0; VMERdDone carries 0xBEEF; sm_timeout_o stays 0.
- TIMEOUT=8: submap write with no Done.
  → VMEWrDone after 8 cycles in SM_WR; sm_timeout_o pulses; err_cnt_o=1. After 300 timeouts err_cnt_o=255.
- Rst asserted 2 cycles into a submap read.
  → no VMERdDone; FSM returns to IDLE; a next register read is acked in 1 cycle.
- VMERdMem and VMEWrMem asserted together at addr 1 with data 0x00FF, ATOMIC=0.
  → write performed, only VMEWrDone asserted, regs_o[15:0]=0x00FF.
